// File: rtl/ram8_clr.sv
// ram8_clr: 8 x 16-bit register file, one write port, one read port, hardware bulk-clear sequencer.
// Latency: write 1 edge; read 0 cycles (1 cycle with RAM8_REG_OUT_EN); clear 9 edges to return to idle.
// Backpressure: busy=1 during clear; load and clear are dropped (not queued) while busy.
//
// Ports:
//   clock   - system clock, all state changes on its rising edge
//   reset   - asynchronous active-high reset, zeroes all words, sequencer and out register
//   in      - 16-bit write data
//   load    - write enable for word address (ignored while busy or when clear is asserted)
//   address - word select, shared by read and write
//   clear   - one-cycle request to zero all eight words
//   out     - read data for word address
//   busy    - high while the clear sequencer is running
//
// Build option: define RAM8_REG_OUT_EN to register out (read-old, 1-cycle read latency).
`timescale 1ns/1ps

module ram8_clr (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] in,
  input  logic        load,
  input  logic [2:0]  address,
  input  logic        clear,
  output logic [15:0] out,
  output logic        busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  cnt;
  logic [15:0] mem [8];
  logic        wr_en;

  // Sequencer next state: leave CLEAR on the edge that zeroes the last word.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clear) state_nxt = CLEAR;
      CLEAR:   if (cnt == 3'd7) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A clear request on the same edge as a load takes priority; the write is dropped.
  assign wr_en = (state == IDLE) && load && !clear;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 3'd0;
      for (int i = 0; i < 8; i++) begin
        mem[i] <= 16'h0000;
      end
    end else begin
      state <= state_nxt;
      if (state == CLEAR) begin
        // cnt wraps 7 -> 0 on the final clearing edge, leaving it ready for the next run.
        mem[cnt] <= 16'h0000;
        cnt      <= cnt + 3'd1;
      end else if (clear) begin
        cnt <= 3'd0;
      end else if (wr_en) begin
        mem[address] <= in;
      end
    end
  end

  // busy comes straight from the state flop, so it is glitch-free.
  assign busy = (state == CLEAR);

`ifdef RAM8_REG_OUT_EN
  // Samples pre-edge contents: a write to the read address shows up one cycle later.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out <= 16'h0000;
    end else begin
      out <= mem[address];
    end
  end
`else
  assign out = mem[address];
`endif

endmodule

// File: tb/tb_ram8_clr.sv
// tb_ram8_clr: directed self-checking bench for ram8_clr (combinational-read build).
// Latency: n/a.
// Backpressure: n/a.
`timescale 1ns/1ps

module tb_ram8_clr;

  logic        clock;
  logic        reset;
  logic [15:0] in;
  logic        load;
  logic [2:0]  address;
  logic        clear;
  logic [15:0] out;
  logic        busy;

  int total = 0;
  int bad   = 0;

  ram8_clr dut (
    .clock   (clock),
    .reset   (reset),
    .in      (in),
    .load    (load),
    .address (address),
    .clear   (clear),
    .out     (out),
    .busy    (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    address = a;
    in      = d;
    load    = 1'b1;
    @(posedge clock);
    #1;
    load    = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [15:0] exp, input string tag);
    address = a;
    #1;
    chk($sformatf("%s_a%0d", tag, a), out, exp);
  endtask

  task automatic fill(input logic [15:0] d);
    for (int i = 0; i < 8; i++) begin
      wr(3'(i), d);
    end
  endtask

  initial begin
    reset   = 1'b1;
    in      = 16'h0000;
    load    = 1'b0;
    address = 3'd0;
    clear   = 1'b0;
    #12;
    reset   = 1'b0;

    // Reset state: all words zero, sequencer idle.
    chk("rst_busy", {15'd0, busy}, 16'd0);
    for (int i = 0; i < 8; i++) rd(3'(i), 16'h0000, "rst_rd");

    // Basic writes and reads.
    wr(3'd3, 16'h1234);
    wr(3'd7, 16'hBEEF);
    rd(3'd3, 16'h1234, "wr_rd");
    rd(3'd7, 16'hBEEF, "wr_rd");
    rd(3'd0, 16'h0000, "wr_rd");

    // Write is not visible before its edge, is visible right after.
    @(posedge clock); #1;
    address = 3'd4;
    in      = 16'h9999;
    load    = 1'b1;
    #1;
    chk("pre_edge", out, 16'h0000);
    @(posedge clock); #1;
    load    = 1'b0;
    chk("post_edge", out, 16'h9999);

    // Clear with a simultaneous load: clear wins.
    fill(16'hFFFF);
    address = 3'd2;
    in      = 16'h5555;
    load    = 1'b1;
    clear   = 1'b1;
    @(posedge clock); #1;
    load    = 1'b0;
    clear   = 1'b0;
    chk("clr_enter_busy", {15'd0, busy}, 16'd1);
    chk("clr_drop_wr", out, 16'hFFFF);
    for (int k = 0; k < 8; k++) begin
      @(posedge clock); #1;
      chk($sformatf("clr_busy_e%0d", k), {15'd0, busy}, (k < 7) ? 16'd1 : 16'd0);
      rd(3'(k), 16'h0000, "clr_done");
      if (k < 7) rd(3'(k + 1), 16'hFFFF, "clr_pend");
    end
    // Earliest write after busy falls.
    wr(3'd5, 16'h0042);
    rd(3'd5, 16'h0042, "post_clr_wr");

    // Clear and load during CLEAR are ignored.
    fill(16'hFFFF);
    clear   = 1'b1;
    @(posedge clock); #1;
    clear   = 1'b0;
    address = 3'd7;
    in      = 16'hAAAA;
    load    = 1'b1;
    for (int k = 0; k < 8; k++) begin
      clear = (k == 2);
      @(posedge clock); #1;
      clear = 1'b0;
      if (k == 7) load = 1'b0;
      chk($sformatf("ign_busy_e%0d", k), {15'd0, busy}, (k < 7) ? 16'd1 : 16'd0);
      if (k < 7) chk($sformatf("ign_w7_e%0d", k), out, 16'hFFFF);
    end
    for (int i = 0; i < 8; i++) rd(3'(i), 16'h0000, "ign_final");

    // Reset mid-clear, between edges.
    fill(16'hFFFF);
    clear = 1'b1;
    @(posedge clock); #1;
    clear = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    address = 3'd5;
    #0.5;
    chk("mid_pre_rst_w5", out, 16'hFFFF);
    chk("mid_pre_rst_busy", {15'd0, busy}, 16'd1);
    reset = 1'b1;
    #0.5;
    chk("mid_rst_busy", {15'd0, busy}, 16'd0);
    for (int i = 0; i < 8; i++) begin
      address = 3'(i);
      #0.25;
      chk($sformatf("mid_rst_a%0d", i), out, 16'h0000);
    end
    reset = 1'b0;
    repeat (3) begin
      @(posedge clock); #1;
      chk("post_rst_busy", {15'd0, busy}, 16'd0);
    end
    wr(3'd1, 16'h0BAD);
    rd(3'd1, 16'h0BAD, "post_rst_wr");
    rd(3'd6, 16'h0000, "post_rst_wr");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
